// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo up/down counter whose state bits are JK flip-flops.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load of load_val
//   load_val  value written on load
//   en        count enable
//   up        direction: 1 = up, 0 = down
//   one_shot  1 = stop in DONE at the terminal event instead of wrapping
//   max_val   modulus minus one (count range 0..max_val)
//   q         registered count
//   q_bar     bitwise complement of q
//   tc        one-cycle pulse following each terminal event
//   running   FSM in RUN
//   done      FSM in DONE
module jk_mod_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q;

  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] tgt;
  logic             step;
  logic             term;

  // Step and terminal detection; max_val/up/one_shot only matter when step is high.
  always_comb begin
    step = en && !clr && !load && (state_q != StDone);
    term = up ? (q_q >= max_val) : (q_q == '0);
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    tog    = '0;
    tog[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      tog[i] = tog[i-1] & (up ? q_q[i-1] : ~q_q[i-1]);
    end
  end

  // JK drive per bit. Forced values use J=v, K=~v; counting uses J=K=toggle; hold uses J=K=0.
  always_comb begin
    j   = '0;
    k   = '0;
    tgt = '0;
    if (clr) begin
      k = '1;
    end else if (load) begin
      j = load_val;
      k = ~load_val;
    end else if (step) begin
      if (term) begin
        if (!one_shot) begin
          tgt = up ? '0 : max_val;
          j   = tgt;
          k   = ~tgt;
        end
      end else begin
        j = tog;
        k = tog;
      end
    end
  end

  // Characteristic equation of a JK flip-flop: Q+ = J~Q | ~K Q.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      tc_q    <= 1'b0;
      state_q <= StIdle;
    end else begin
      q_q  <= q_d;
      tc_q <= step && term;
      if (clr || load) begin
        state_q <= StIdle;
      end else if (step) begin
        state_q <= (term && one_shot) ? StDone : StRun;
      end else if (state_q == StRun && !en) begin
        state_q <= StIdle;
      end
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign tc      = tc_q;
  assign running = (state_q == StRun);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH = 4).
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up, one_shot;
  logic [3:0] load_val, max_val;
  logic [3:0] q, q_bar;
  logic       tc, running, done;

  int n_tests = 0;
  int n_fail  = 0;

  jk_mod_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .one_shot (one_shot),
    .max_val  (max_val),
    .q        (q),
    .q_bar    (q_bar),
    .tc       (tc),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check against expected q/tc/running/done; q_bar derived from expected q.
  task automatic expect_all(input string tag, input logic [3:0] eq, input logic etc,
                            input logic erun, input logic edone);
    logic [3:0] eqb;
    eqb = ~eq;
    check({tag, ".q"},     32'(q),       32'(eq));
    check({tag, ".q_bar"}, 32'(q_bar),   32'(eqb));
    check({tag, ".tc"},    32'(tc),      32'(etc));
    check({tag, ".run"},   32'(running), 32'(erun));
    check({tag, ".done"},  32'(done),    32'(edone));
  endtask

  initial begin
    logic [3:0] seq_dn [4];
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; one_shot = 1'b0;
    load_val = 4'd0; max_val = 4'd9;

    // Reset state, held across an edge with en=1 and load asserted.
    #2;
    expect_all("rst", 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd6;
    tick();
    expect_all("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    rst_n = 1'b1;

    // Up count 0..9 then wrap; tc only on the wrap cycle.
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_all($sformatf("up%0d", i), 4'(i % 10), (i == 10), 1'b1, 1'b0);
    end

    // Load 3 then count down with wrap to max_val.
    load = 1'b1; load_val = 4'd3; up = 1'b0;
    tick();
    expect_all("ld3", 4'd3, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    seq_dn[0] = 4'd2; seq_dn[1] = 4'd1; seq_dn[2] = 4'd0; seq_dn[3] = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_all($sformatf("dn%0d", i), seq_dn[i], (i == 3), 1'b1, 1'b0);
    end
    en = 1'b0;
    tick();
    expect_all("en_off", 4'd9, 1'b0, 1'b0, 1'b0);

    // One-shot up to 3: holds, DONE, single tc, en ignored; load leaves DONE.
    clr = 1'b1;
    tick();
    expect_all("clr", 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; one_shot = 1'b1; up = 1'b1; max_val = 4'd3; en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_all($sformatf("os%0d", i), 4'(i), 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_all("os_term", 4'd3, 1'b1, 1'b0, 1'b1);
    up = 1'b0; one_shot = 1'b0;
    tick();
    expect_all("os_hold1", 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    expect_all("os_hold2", 4'd3, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_val = 4'd1;
    tick();
    expect_all("os_ld1", 4'd1, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0; max_val = 4'd9; up = 1'b1;

    // Async reset between edges.
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    check("pre_async.q", 32'(q), 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_all("async", 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;

    // clr beats load beats step.
    load = 1'b1; load_val = 4'd5;
    tick();
    clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    expect_all("clr_pri", 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    expect_all("ld_pri", 4'd7, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;

    // max_val = 0 up: q stays 0 with tc every cycle.
    clr = 1'b1;
    tick();
    clr = 1'b0; max_val = 4'd0; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("m0_%0d", i), 4'd0, 1'b1, 1'b1, 1'b0);
    end

    // load_val above max_val: up wraps to 0, down decrements normally.
    max_val = 4'd9; load = 1'b1; load_val = 4'd12;
    tick();
    expect_all("ld12", 4'd12, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    expect_all("ld12_up", 4'd0, 1'b1, 1'b1, 1'b0);
    load = 1'b1;
    tick();
    load = 1'b0; up = 1'b0;
    tick();
    expect_all("ld12_dn", 4'd11, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
